// File: rtl/cpu_run_ctl.sv
// CPU run/halt/step/breakpoint controller that issues a divided clock enable to the CPU core.
// Define RUN_CTL_CYCLE_COUNT_EN to build the issued-enable counter on cycle_cnt.
module cpu_run_ctl #(
    parameter int DIV_W  = 17,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  div_val,
    input  logic              run,
    input  logic              step_req,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              fetch_strobe,
    output logic              cpu_en,
    output logic              halted,
    output logic              bp_hit,
    output logic [1:0]        state_out,
    output logic [31:0]       cycle_cnt
);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_BRK  = 2'd3
    } state_t;

    state_t            state, nstate;
    logic [DIV_W-1:0]  cnt;
    logic              tick;
    logic              step_first;
    logic              bp_match;
    logic              active;

    assign bp_match = bp_en && fetch_strobe && (pc_addr == bp_addr);

    always_comb begin
        nstate = state;
        cpu_en = 1'b0;
        case (state)
            S_HALT: begin
                if (run)           nstate = S_RUN;
                else if (step_req) nstate = S_STEP;
            end
            S_RUN: begin
                if (!run)          nstate = S_HALT;
                else if (tick) begin
                    if (bp_match)  nstate = S_BRK;
                    else           cpu_en = 1'b1;
                end
            end
            S_STEP: begin
                if (tick) begin
                    if (step_first)        cpu_en = 1'b1;
                    else if (fetch_strobe) nstate = S_HALT;
                    else                   cpu_en = 1'b1;
                end
            end
            S_BRK: begin
                if (!run)          nstate = S_HALT;
            end
            default:               nstate = S_HALT;
        endcase
    end

    // Count only while staying in RUN/STEP, so the first tick lands div_val+1 cycles after entry.
    assign active = ((state == S_RUN) || (state == S_STEP)) &&
                    ((nstate == S_RUN) || (nstate == S_STEP));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_HALT;
            cnt        <= '0;
            tick       <= 1'b0;
            step_first <= 1'b0;
        end else begin
            state <= nstate;
            if (!active) begin
                cnt  <= '0;
                tick <= 1'b0;
            end else if (cnt >= div_val) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + {{(DIV_W-1){1'b0}}, 1'b1};
                tick <= 1'b0;
            end
            if (state == S_HALT && nstate == S_STEP)
                step_first <= 1'b1;
            else if (state == S_STEP && tick)
                step_first <= 1'b0;
        end
    end

    assign halted    = (state == S_HALT) || (state == S_BRK);
    assign bp_hit    = (state == S_BRK);
    assign state_out = state;

`ifdef RUN_CTL_CYCLE_COUNT_EN
    logic [31:0] cyc_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         cyc_q <= '0;
        else if (cpu_en) cyc_q <= cyc_q + 32'd1;
    end
    assign cycle_cnt = cyc_q;
`else
    assign cycle_cnt = '0;
`endif

endmodule

// File: doc/cpu_run_ctl.md
CPU_RUN_CTL -- requirements
Module: cpu_run_ctl

Interface
REQ-001 SHALL have parameter DIV_W, default 17: width of the clock-enable divider counter and div_val.
REQ-002 SHALL have parameter ADDR_W, default 16: width of pc_addr and bp_addr.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port div_val  input  DIV_W  enable period minus one; 0 = enable every cycle.
REQ-006 SHALL have port run  input  1  level; 1 requests free-run.
REQ-007 SHALL have port step_req  input  1  single-cycle pulse; requests one-instruction step.
REQ-008 SHALL have port bp_en  input  1  breakpoint enable.
REQ-009 SHALL have port bp_addr  input  ADDR_W  breakpoint opcode address.
REQ-010 SHALL have port pc_addr  input  ADDR_W  CPU address of the current cycle.
REQ-011 SHALL have port fetch_strobe  input  1  high when the current CPU cycle is an opcode fetch.
REQ-012 SHALL have port cpu_en  output  1  one-cycle clock enable to every CPU register.
REQ-013 SHALL have port halted  output  1  high in HALT or BRK.
REQ-014 SHALL have port bp_hit  output  1  high in BRK.
REQ-015 SHALL have port state_out  output  2  encoding HALT=0, RUN=1, STEP=2, BRK=3.
REQ-016 SHALL have port cycle_cnt  output  32  count of issued cpu_en pulses.

Function
REQ-017 Divider counter SHALL be held at 0 in HALT and BRK, increment each cycle in RUN and STEP, and produce tick when cnt >= div_val, returning to 0 on tick.
REQ-018 First tick after entering RUN or STEP SHALL occur div_val+1 cycles after the state change; div_val changes apply immediately, and a value below the current count ticks on the next cycle.
REQ-019 HALT: cpu_en=0; run=1 -> RUN; else step_req=1 -> STEP; both asserted -> RUN.
REQ-020 RUN: cpu_en=tick; run=0 -> HALT with no enable that cycle; run=0 SHALL take priority over a breakpoint match in the same cycle.
REQ-021 RUN breakpoint: tick & bp_en & fetch_strobe & pc_addr==bp_addr SHALL suppress cpu_en for that cycle and move to BRK.
REQ-022 STEP: the first tick SHALL always produce cpu_en, even at a breakpoint address; each later tick SHALL produce cpu_en unless fetch_strobe=1, in which case cpu_en is suppressed and the state moves to HALT.
REQ-023 STEP: run and step_req SHALL be ignored until the step completes; run still high after completion -> RUN on the next cycle.
REQ-024 BRK: cpu_en=0; run=0 -> HALT; step_req SHALL be ignored.
REQ-025 cpu_en SHALL never be high for two consecutive cycles unless div_val=0.

Reset
REQ-026 Asserting rst SHALL immediately force: state HALT, divider 0, cpu_en=0, bp_hit=0, halted=1, state_out=0, cycle_cnt=0, step-first flag clear.
REQ-027 Reset mid-RUN or mid-STEP SHALL abandon the operation; after release the block SHALL wait in HALT for run or step_req.

Configuration
REQ-028 With RUN_CTL_CYCLE_COUNT_EN defined, cycle_cnt SHALL increment (mod 2^32) on every cycle with cpu_en=1.
REQ-029 Without RUN_CTL_CYCLE_COUNT_EN, cycle_cnt SHALL be constant 0 and the counter SHALL not be built.

Verification
REQ-030 div_val=3; run rises at cycle 0 -> state RUN at cycle 1, cpu_en at cycles 5, 9, 13; run falls -> cpu_en stays 0 and halted=1 next cycle.
REQ-031 div_val=0, HALT; step_req pulse; fetch_strobe high on the 1st and 4th enabled cycles -> exactly 3 cpu_en pulses, then HALT.
REQ-032 div_val=0, bp_en=1, bp_addr=0x0203; run with fetch_strobe & pc_addr=0x0203 -> no cpu_en that cycle, bp_hit=1, state_out=3; run=0 -> HALT; step_req -> fetch at 0x0203 enabled.
REQ-033 div_val=7, RUN at count 5; set div_val=2 -> tick next cycle, then a period of 3.
REQ-034 rst asserted mid-STEP between clock edges -> cpu_en=0 and state_out=0 before the next edge; cycle_cnt=0.
REQ-035 With the macro defined: 10 enabled cycles -> cycle_cnt=10; without the macro -> cycle_cnt=0 throughout.
